// File: rtl/control_sequencer.sv
// Six-T-state microcoded control unit for the 8-bit bus CPU: one-hot ring counter, halt latch.
// Optional CTRL_JMP_EN enables the JMP opcode (T4 loads PC from the IR address nibble).
module control_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    output logic [5:0] tstate,
    output logic       halt,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       acc_load,
    output logic       acc_out,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       breg_load,
    output logic       out_load
);
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_e;

    state_e state_q, state_d;
    logic   halted_q, halted_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Halting freezes the ring at T4; only clr leaves that state.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (!halted_q) begin
            case (state_q)
                T1: state_d = T2;
                T2: state_d = T3;
                T3: state_d = T4;
                T4: begin
                    if (opcode == OP_HLT) halted_d = 1'b1;
                    else                  state_d  = T5;
                end
                T5: state_d = T6;
                T6: state_d = T1;
                default: state_d = T1;
            endcase
        end
    end

    always_comb begin
        halt      = 1'b0;
        pc_inc    = 1'b0;
        pc_out    = 1'b0;
        pc_load   = 1'b0;
        mar_load  = 1'b0;
        ram_out   = 1'b0;
        ir_load   = 1'b0;
        ir_out    = 1'b0;
        acc_load  = 1'b0;
        acc_out   = 1'b0;
        alu_sub   = 1'b0;
        alu_out   = 1'b0;
        breg_load = 1'b0;
        out_load  = 1'b0;
        if (!clr) begin
            if (halted_q) begin
                halt = 1'b1;
            end else begin
                case (state_q)
                    T1: begin
                        pc_out   = 1'b1;
                        mar_load = 1'b1;
                    end
                    T2: pc_inc = 1'b1;
                    T3: begin
                        ram_out = 1'b1;
                        ir_load = 1'b1;
                    end
                    T4: begin
                        case (opcode)
                            OP_LDA, OP_ADD, OP_SUB: begin
                                ir_out   = 1'b1;
                                mar_load = 1'b1;
                            end
                            OP_OUT: begin
                                acc_out  = 1'b1;
                                out_load = 1'b1;
                            end
                            OP_HLT: halt = 1'b1;
`ifdef CTRL_JMP_EN
                            OP_JMP: begin
                                ir_out  = 1'b1;
                                pc_load = 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                    T5: begin
                        case (opcode)
                            OP_LDA: begin
                                ram_out  = 1'b1;
                                acc_load = 1'b1;
                            end
                            OP_ADD, OP_SUB: begin
                                ram_out   = 1'b1;
                                breg_load = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    T6: begin
                        // Only ADD/SUB write back through the ALU; SUB also selects subtract.
                        if (opcode == OP_ADD || opcode == OP_SUB) begin
                            alu_out  = 1'b1;
                            acc_load = 1'b1;
                            alu_sub  = (opcode == OP_SUB);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tstate = state_q;
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Control unit that consumes the 4-bit opcode presented by the instruction register.
- Generates the per-T-state control word that drives the PC, MAR, RAM, instruction register, accumulator, B register, ALU and output register in the 8-bit bus CPU.
- Drives the instruction register's write and output enables (ir_load, ir_out).
- One-hot six-state ring counter; fixed 6-clock instruction cycle; halt latch.

Parameters:
- OP_LDA, 4'h0, load accumulator from RAM[addr]
- OP_ADD, 4'h1, acc = acc + RAM[addr]
- OP_SUB, 4'h2, acc = acc - RAM[addr]
- OP_JMP, 4'h3, PC = addr (only with CTRL_JMP_EN)
- OP_OUT, 4'hE, output register = acc
- OP_HLT, 4'hF, stop sequencing

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- opcode  in  4  instruction opcode from the instruction register; valid T4..T6
- tstate  out  6  one-hot ring state, bit0=T1 .. bit5=T6
- halt  out  1  CPU halted
- pc_inc  out  1  increment PC
- pc_out  out  1  PC drives bus
- pc_load  out  1  PC loads from bus
- mar_load  out  1  MAR loads from bus
- ram_out  out  1  RAM drives bus
- ir_load  out  1  instruction register write enable
- ir_out  out  1  instruction register address nibble drives bus
- acc_load  out  1  accumulator loads from bus
- acc_out  out  1  accumulator drives bus
- alu_sub  out  1  ALU subtract select
- alu_out  out  1  ALU drives bus
- breg_load  out  1  B register loads from bus
- out_load  out  1  output register loads from bus

Behaviour:
- Reset: clk edge with clr=1 sets tstate=6'b000001 and halted=0. While clr=1, all control outputs and halt are forced 0 combinationally. clr mid-instruction aborts the instruction; the next cycle is T1.
- Ring counter: each clk edge with clr=0 and halted=0 advances T1->T2->..->T6->T1.
- Control outputs are combinational from tstate, opcode and halted. The downstream register captures on the edge that ends the T-state.
- Microcode, all unlisted outputs 0:
  - T1: pc_out, mar_load
  - T2: pc_inc
  - T3: ram_out, ir_load
  - T4 LDA/ADD/SUB: ir_out, mar_load
  - T4 OUT: acc_out, out_load
  - T4 HLT: halt
  - T5 LDA: ram_out, acc_load
  - T5 ADD/SUB: ram_out, breg_load
  - T6 ADD: alu_out, acc_load
  - T6 SUB: alu_sub, alu_out, acc_load
- Unlisted opcodes are NOPs: T4..T6 all outputs 0, cycle still 6 clocks.
- Halt:
  - On the edge ending T4 with opcode=OP_HLT, halted<=1 and tstate holds at T4.
  - While halted: halt=1, all other control outputs 0, opcode changes ignored.
  - Only clr exits halt.
- Invariant: at most one of pc_out, ram_out, ir_out, acc_out, alu_out is asserted in any cycle.
- ir_load is asserted only in T3. ir_out is asserted only in T4, and in T4 only for opcodes that address memory or jump.

Optional Feature:
- Macro: CTRL_JMP_EN.
- Defined: OP_JMP at T4 asserts ir_out and pc_load; T5/T6 outputs 0. The next T1 fetches from the loaded address.
- Undefined: OP_JMP decodes as a NOP and pc_load is tied 0. The port is always present.

Test Plan:
- Reset: hold clr=1 for 2 clocks -> tstate=000001, all outputs 0. Release clr -> tstate walks 000001,000010,000100,001000,010000,100000,000001.
- LDA: opcode=4'h0 -> T1 {pc_out,mar_load}, T2 {pc_inc}, T3 {ram_out,ir_load}, T4 {ir_out,mar_load}, T5 {ram_out,acc_load}, T6 none.
- SUB: opcode=4'h2 -> T5 {ram_out,breg_load}, T6 {alu_sub,alu_out,acc_load}. With opcode=4'h1, T6 has alu_sub=0.
- HLT: opcode=4'hF -> halt=1 from T4 onward. tstate frozen at 001000 for 20 clocks with all other outputs 0. Pulse clr -> tstate=000001, halt=0.
- Mid-instruction reset: assert clr during T5 of ADD -> next cycle T1, breg_load never asserted after the clr edge.
- JMP/NOP plus invariant: opcode=4'h3 -> with CTRL_JMP_EN, T4 {ir_out,pc_load}; without it, T4..T6 all 0. A random opcode stream over 1000 cycles never asserts two bus drivers at once.
